// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR amplitude envelope applied to a signed 16-bit sample, level advanced on a prescaled tick.
// Define ADSR_ENVELOPE_EXP_RELEASE_EN for an exponential-like release tail with a linear floor.
module adsr_envelope #(
    parameter int unsigned TICK_DIV = 4800
) (
    input  logic               clk48m,
    input  logic               rst_n,
    input  logic               gate,
    input  logic        [15:0] attack_step,
    input  logic        [15:0] decay_step,
    input  logic        [15:0] sustain_level,
    input  logic        [15:0] release_step,
    input  logic signed [15:0] signal_in,
    output logic signed [15:0] signal_out,
    output logic        [15:0] level,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_e;

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    state_e             state_q, state_d, edge_state;
    logic        [15:0] presc_q, presc_d, level_q, level_d, rel_dec;
    logic               gate_q, busy_q, busy_d, tick, rise, fall;
    logic signed [15:0] out_q, out_d;
    logic        [16:0] att_sum, dec_thr;
    logic signed [32:0] prod;

    assign tick    = presc_q == LAST;
    assign presc_d = tick ? 16'd0 : presc_q + 16'd1;
    assign rise    = gate & ~gate_q;
    assign fall    = ~gate & gate_q;
    assign att_sum = {1'b0, level_q} + {1'b0, attack_step};
    assign dec_thr = {1'b0, sustain_level} + {1'b0, decay_step};
`ifdef ADSR_ENVELOPE_EXP_RELEASE_EN
    assign rel_dec = (level_q >> 4) > release_step ? level_q >> 4 : release_step;
`else
    assign rel_dec = release_step;
`endif

    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            presc_q <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            presc_q <= presc_d;
            gate_q  <= gate;
            busy_q  <= busy_d;
            out_q   <= out_d;
        end
    end

    // Gate edges override the current state first; the tick then follows the resulting state's rule.
    always_comb begin
        edge_state = state_q;
        if (rise && (state_q == IDLE || state_q == RELEASE))
            edge_state = ATTACK;
        else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN))
            edge_state = RELEASE;
        state_d = edge_state;
        level_d = level_q;
        if (tick) begin
            case (edge_state)
                ATTACK: begin
                    level_d = att_sum >= 17'd65535 ? 16'hFFFF : att_sum[15:0];
                    state_d = att_sum >= 17'd65535 ? DECAY : ATTACK;
                end
                DECAY: begin
                    level_d = {1'b0, level_q} <= dec_thr ? sustain_level : level_q - decay_step;
                    state_d = {1'b0, level_q} <= dec_thr ? SUSTAIN : DECAY;
                end
                SUSTAIN: level_d = sustain_level;
                RELEASE: begin
                    level_d = level_q <= rel_dec ? 16'd0 : level_q - rel_dec;
                    state_d = level_q <= rel_dec ? IDLE : RELEASE;
                end
                default: level_d = '0;
            endcase
        end
    end

    // Gain is at most 65535/65536, so the floored upper half never overflows.
    always_comb begin
        prod   = $signed(signal_in) * $signed({1'b0, level_q});
        out_d  = prod[31:16];
        busy_d = state_d != IDLE;
    end

    assign signal_out = out_q;
    assign level      = level_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed checks of adsr_envelope with TICK_DIV=4, sampling on the falling clock edge.
module tb_adsr_envelope;
    logic               clk48m = 1'b0;
    logic               rst_n  = 1'b0;
    logic               gate   = 1'b0;
    logic        [15:0] attack_step   = 16'd16384;
    logic        [15:0] decay_step    = 16'd4096;
    logic        [15:0] sustain_level = 16'd32768;
    logic        [15:0] release_step  = 16'd8192;
    logic signed [15:0] signal_in     = 16'sh7FFF;
    logic signed [15:0] signal_out;
    logic        [15:0] level;
    logic               busy;
    int                 total = 0;
    int                 fails = 0;

    adsr_envelope #(.TICK_DIV(4)) dut (
        .clk48m(clk48m), .rst_n(rst_n), .gate(gate),
        .attack_step(attack_step), .decay_step(decay_step),
        .sustain_level(sustain_level), .release_step(release_step),
        .signal_in(signal_in), .signal_out(signal_out),
        .level(level), .busy(busy)
    );

    initial forever #5 clk48m = ~clk48m;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk48m);
    endtask

    initial begin
        nclk(2);
        check("reset_level", level, 0);
        check("reset_busy", busy, 0);
        check("reset_out", signal_out, 0);
        rst_n = 1'b1;
        nclk(10);
        check("idle_level", level, 0);
        check("idle_busy", busy, 0);
        gate = 1'b1;
        nclk(1);
        check("rise_busy", busy, 1);
        check("rise_level", level, 0);
        nclk(1);
        check("attack_t1", level, 16384);
        nclk(4);
        check("attack_t2", level, 32768);
        nclk(4);
        check("attack_t3", level, 49152);
        nclk(4);
        check("attack_t4", level, 65535);
        check("out_latency", signal_out, 24575);
        nclk(1);
        check("out_max_pos", signal_out, 32766);
        signal_in = 16'sh8000;
        nclk(1);
        check("out_max_neg", signal_out, -32768);
        signal_in = 16'sh7FFF;
        nclk(29);
        check("decay_t7", level, 36863);
        nclk(1);
        check("decay_t8", level, 32768);
        check("sustain_busy", busy, 1);
        nclk(1);
        check("sustain_out", signal_out, 16383);
        nclk(1);
        gate = 1'b0;
        nclk(2);
        check("release_t1", level, 24576);
        nclk(12);
        check("release_end", level, 0);
        check("release_busy", busy, 0);
        nclk(1);
        check("out_zero", signal_out, 0);
        nclk(1);
        attack_step = 16'd20000;
        gate = 1'b1;
        nclk(2);
        check("re_attack1", level, 20000);
        nclk(4);
        check("re_attack2", level, 40000);
        gate = 1'b0;
        nclk(1);
        check("re_rel_busy", busy, 1);
        check("re_rel_level", level, 40000);
        nclk(1);
        gate = 1'b1;
        nclk(1);
        check("retrig_hold", level, 40000);
        nclk(1);
        check("retrig_resume", level, 60000);
        nclk(4);
        check("retrig_sat", level, 65535);
        gate = 1'b0;
        release_step = 16'd65535;
        nclk(4);
        check("big_rel_level", level, 0);
        check("big_rel_busy", busy, 0);
        attack_step = 16'd16384;
        release_step = 16'd8192;
        gate = 1'b1;
        nclk(8);
        check("coll_pre", level, 32768);
        nclk(3);
        gate = 1'b0;
        nclk(1);
        check("coll_level", level, 24576);
        check("coll_busy", busy, 1);
        gate = 1'b1;
        nclk(2);
        check("pre_rst_level", level, 24576);
        #2 rst_n = 1'b0;
        #1;
        check("async_level", level, 0);
        check("async_busy", busy, 0);
        check("async_out", signal_out, 0);
        nclk(1);
        attack_step = 16'd65535;
        rst_n = 1'b1;
        nclk(1);
        check("held_gate_busy", busy, 1);
        check("held_gate_level", level, 0);
        nclk(3);
        check("full_attack", level, 65535);
        gate = 1'b0;
        nclk(1);
        release_step = 16'd1;
        nclk(3);
`ifdef ADSR_ENVELOPE_EXP_RELEASE_EN
        check("exp_release", level, 61440);
`else
        check("lin_release", level, 65534);
`endif
        release_step = 16'd65535;
        nclk(4);
        check("final_level", level, 0);
        check("final_busy", busy, 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
